// File: rtl/m26_arb_pkg.sv
// rtl/m26_arb_pkg.sv - shared types and round-robin helper for the Mimosa26 FIFO arbiter
package m26_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    localparam int          GID_W  = 4;
    localparam int unsigned MAX_CH = 1 << GID_W;

    // First set bit of req after last, wrapping at n; returns 0 when req is empty.
    function automatic logic [GID_W-1:0] rr_next(
        input logic [MAX_CH-1:0] req,
        input logic [GID_W-1:0]  last,
        input int unsigned       n
    );
        logic [GID_W-1:0] pick;
        logic             found;
        int unsigned      idx;
        pick  = '0;
        found = 1'b0;
        for (int unsigned k = 1; k <= MAX_CH; k++) begin
            idx = (32'(last) + k) % n;
            if (!found && (k <= n) && req[idx[GID_W-1:0]]) begin
                pick  = idx[GID_W-1:0];
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/m26_fifo_arbiter_if.sv
// rtl/m26_fifo_arbiter_if.sv - channel-side and downstream FWFT FIFO signals of the arbiter
interface m26_fifo_arbiter_if #(
    parameter int CHANNELS = 6
);
    logic [CHANNELS-1:0]    FIFO_EMPTY_CH;
    logic [32*CHANNELS-1:0] FIFO_DATA_CH;
    logic [CHANNELS-1:0]    FIFO_READ_CH;
    logic                   FIFO_READ;
    logic                   FIFO_EMPTY;
    logic [31:0]            FIFO_DATA;

    modport master (
        input  FIFO_EMPTY_CH, FIFO_DATA_CH, FIFO_READ,
        output FIFO_READ_CH, FIFO_EMPTY, FIFO_DATA
    );

    modport slave (
        output FIFO_EMPTY_CH, FIFO_DATA_CH, FIFO_READ,
        input  FIFO_READ_CH, FIFO_EMPTY, FIFO_DATA
    );
endinterface

// File: rtl/m26_rr_pick.sv
// rtl/m26_rr_pick.sv - combinational rotating-priority picker
module m26_rr_pick
    import m26_arb_pkg::*;
#(
    parameter int CHANNELS = 6
) (
    input  logic [CHANNELS-1:0] req_i,
    input  logic [GID_W-1:0]    last_i,
    output logic [GID_W-1:0]    pick_o,
    output logic                any_o
);

    logic [MAX_CH-1:0] req_ext;

    always_comb begin
        req_ext                = '0;
        req_ext[CHANNELS-1:0]  = req_i;
    end

    assign pick_o = rr_next(req_ext, last_i, CHANNELS);
    assign any_o  = |req_i;

endmodule

// File: rtl/m26_fifo_arbiter.sv
// rtl/m26_fifo_arbiter.sv - round-robin burst merge of per-plane FWFT FIFOs into one stream
module m26_fifo_arbiter
    import m26_arb_pkg::*;
#(
    parameter int CHANNELS  = 6,
    parameter int MAX_BURST = 16,
    parameter int CNT_WIDTH = 32
) (
    input  logic                 BUS_CLK,
    input  logic                 BUS_RST,
    input  logic [CHANNELS-1:0]  ENABLE,
    m26_fifo_arbiter_if.master   bus,
    output logic [GID_W-1:0]     GRANT_ID,
    output logic                 GRANT_VALID,
    output logic [CNT_WIDTH-1:0] WORD_COUNT
);

    localparam int BURST_W = $clog2(MAX_BURST + 1);

    arb_state_t           state_q;
    logic [GID_W-1:0]     grant_q;
    logic [GID_W-1:0]     last_q;
    logic [BURST_W-1:0]   burst_q;
    logic [CNT_WIDTH-1:0] count_q;

    logic [CHANNELS-1:0]  req;
    logic [GID_W-1:0]     pick;
    logic                 any;
    logic                 g_empty;
    logic                 g_en;
    logic [31:0]          g_data;
    logic                 active;
    logic                 pop;
    logic                 burst_done;
    logic [CHANNELS-1:0]  read_ch;

    assign req = ~bus.FIFO_EMPTY_CH & ENABLE;

    m26_rr_pick #(
        .CHANNELS (CHANNELS)
    ) u_pick (
        .req_i  (req),
        .last_i (last_q),
        .pick_o (pick),
        .any_o  (any)
    );

    always_comb begin
        g_empty = 1'b1;
        g_en    = 1'b0;
        g_data  = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (grant_q == GID_W'(i)) begin
                g_empty = bus.FIFO_EMPTY_CH[i];
                g_en    = ENABLE[i];
                g_data  = bus.FIFO_DATA_CH[32*i +: 32];
            end
        end
    end

    // Reset wins over a pending pop so the downstream never sees a word that was not taken.
    assign active     = (state_q == GRANT) && !BUS_RST;
    assign pop        = active && bus.FIFO_READ && !g_empty && g_en;
    assign burst_done = (burst_q == BURST_W'(MAX_BURST - 1));

    always_comb begin
        read_ch = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            read_ch[i] = pop && (grant_q == GID_W'(i));
        end
    end

    assign bus.FIFO_READ_CH = read_ch;
    assign bus.FIFO_EMPTY   = !(active && !g_empty && g_en);
    assign bus.FIFO_DATA    = active ? g_data : 32'h0;

    always_ff @(posedge BUS_CLK) begin
        if (BUS_RST) begin
            state_q <= IDLE;
            last_q  <= GID_W'(CHANNELS - 1);
            grant_q <= '0;
            burst_q <= '0;
            count_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (any) begin
                        grant_q <= pick;
                        last_q  <= pick;
                        burst_q <= '0;
                        state_q <= GRANT;
                    end
                end
                GRANT: begin
                    if (pop) begin
                        burst_q <= burst_q + 1'b1;
                        count_q <= count_q + 1'b1;
                    end
                    if ((pop && burst_done) || g_empty || !g_en) begin
                        state_q <= IDLE;
                    end
                end
            endcase
        end
    end

    assign GRANT_ID    = grant_q;
    assign GRANT_VALID = (state_q == GRANT);
    assign WORD_COUNT  = count_q;

endmodule
